// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions, interrupts and mret, then
// sequences the CSR writes and the PC redirect. Vectored mtvec support under TRAP_VECTORED_EN.
module trap_ctrl #(
    parameter int XLEN             = 64,
    parameter int NUM_IRQ          = 12,
    parameter int RESET_MTVEC_ONLY = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     pc_i,
    input  logic                jump_i,
    input  logic [XLEN-1:0]     jump_pc_i,
    input  logic [3:0]          expt_info_i,
    input  logic [NUM_IRQ-1:0]  irq_pend_i,
    input  logic [NUM_IRQ-1:0]  irq_en_i,
    input  logic                global_int_en_i,
    input  logic [XLEN-1:0]     csr_mtvec_i,
    input  logic [XLEN-1:0]     csr_mepc_i,
    input  logic [XLEN-1:0]     csr_mstatus_i,
    output logic                mepc_wen_o,
    output logic [XLEN-1:0]     mepc_wdata_o,
    output logic                mcause_wen_o,
    output logic [XLEN-1:0]     mcause_wdata_o,
    output logic                mstatus_wen_o,
    output logic [XLEN-1:0]     mstatus_wdata_o,
    output logic                trap_valid_o,
    output logic [XLEN-1:0]     trap_addr_o,
    output logic [NUM_IRQ-1:0]  irq_ack_o,
    output logic                hold_o
);

    localparam int IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

`ifdef TRAP_VECTORED_EN
    localparam bit VEC_BUILD = 1'b1;
`else
    localparam bit VEC_BUILD = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        REDIR = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_EXC  = 2'd0,
        K_IRQ  = 2'd1,
        K_MRET = 2'd2
    } kind_t;

    state_t              state_q, state_d;
    kind_t               kind_q, kind_d;
    logic [IDXW-1:0]     idx_q, idx_win;
    logic [NUM_IRQ-1:0]  act;
    logic                irq_hit;
    logic                take_trap, take_mret;
    logic [XLEN-1:0]     epc_d, cause_d;
    logic [XLEN-1:0]     mepc_q, mcause_q, mstatus_q, addr_q;
    logic [XLEN-1:0]     trap_base, vec_off;
    logic                use_vec;

    // Highest-index qualified interrupt wins
    always_comb begin
        act     = global_int_en_i ? (irq_pend_i & irq_en_i) : '0;
        irq_hit = |act;
        idx_win = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (act[i]) idx_win = IDXW'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        take_trap = 1'b0;
        take_mret = 1'b0;
        cause_d   = '0;
        epc_d     = pc_i;
        case (state_q)
            IDLE: begin
                if (expt_info_i[3]) begin
                    take_trap = 1'b1;
                    kind_d    = K_EXC;
                    cause_d   = XLEN'(2);
                end else if (expt_info_i[2]) begin
                    take_trap = 1'b1;
                    kind_d    = K_EXC;
                    cause_d   = XLEN'(11);
                end else if (expt_info_i[1]) begin
                    take_trap = 1'b1;
                    kind_d    = K_EXC;
                    cause_d   = XLEN'(3);
                end else if (irq_hit) begin
                    take_trap         = 1'b1;
                    kind_d            = K_IRQ;
                    cause_d           = XLEN'(idx_win);
                    cause_d[XLEN-1]   = 1'b1;
                    epc_d             = jump_i ? jump_pc_i : pc_i;
                end else if (expt_info_i[0]) begin
                    take_mret = 1'b1;
                    kind_d    = K_MRET;
                end
                if (take_trap)      state_d = TRAP;
                else if (take_mret) state_d = REDIR;
            end
            TRAP:    state_d = REDIR;
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            kind_q    <= K_EXC;
            idx_q     <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mstatus_q <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            mstatus_q <= mstatus_wdata_o;
            addr_q    <= trap_addr_o;
            if (take_trap) begin
                mepc_q   <= epc_d;
                mcause_q <= cause_d;
                idx_q    <= idx_win;
            end
        end
    end

    assign trap_base = {csr_mtvec_i[XLEN-1:2], 2'b00};
    assign vec_off   = XLEN'(idx_q) << 2;
    assign use_vec   = VEC_BUILD && (RESET_MTVEC_ONLY == 0) &&
                       (csr_mtvec_i[1:0] == 2'b01) && (kind_q == K_IRQ);

    // Write data and redirect target follow live CSR values during their pulse, then hold
    always_comb begin
        mepc_wen_o      = (state_q == TRAP);
        mcause_wen_o    = (state_q == TRAP);
        mstatus_wen_o   = (state_q == TRAP) || (state_q == REDIR && kind_q == K_MRET);
        mepc_wdata_o    = mepc_q;
        mcause_wdata_o  = mcause_q;
        mstatus_wdata_o = mstatus_q;
        trap_valid_o    = (state_q == REDIR);
        trap_addr_o     = addr_q;
        irq_ack_o       = '0;
        if (state_q == TRAP) begin
            mstatus_wdata_o        = csr_mstatus_i;
            mstatus_wdata_o[7]     = csr_mstatus_i[3];
            mstatus_wdata_o[3]     = 1'b0;
            mstatus_wdata_o[12:11] = 2'b11;
            if (kind_q == K_IRQ) irq_ack_o = NUM_IRQ'(1) << idx_q;
        end
        if (state_q == REDIR) begin
            if (kind_q == K_MRET) begin
                mstatus_wdata_o        = csr_mstatus_i;
                mstatus_wdata_o[3]     = csr_mstatus_i[7];
                mstatus_wdata_o[7]     = 1'b1;
                mstatus_wdata_o[12:11] = 2'b11;
                trap_addr_o            = csr_mepc_i;
            end else begin
                trap_addr_o = use_vec ? (trap_base + vec_off) : trap_base;
            end
        end
    end

    assign hold_o = (state_q != IDLE) || take_trap || take_mret;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl (default parameters).
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_i, jump_pc_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        jump_i, global_int_en_i;
    logic [3:0]  expt_info_i;
    logic [11:0] irq_pend_i, irq_en_i;
    logic        mepc_wen_o, mcause_wen_o, mstatus_wen_o, trap_valid_o, hold_o;
    logic [63:0] mepc_wdata_o, mcause_wdata_o, mstatus_wdata_o, trap_addr_o;
    logic [11:0] irq_ack_o;

    int total = 0;
    int bad   = 0;

    trap_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .pc_i            (pc_i),
        .jump_i          (jump_i),
        .jump_pc_i       (jump_pc_i),
        .expt_info_i     (expt_info_i),
        .irq_pend_i      (irq_pend_i),
        .irq_en_i        (irq_en_i),
        .global_int_en_i (global_int_en_i),
        .csr_mtvec_i     (csr_mtvec_i),
        .csr_mepc_i      (csr_mepc_i),
        .csr_mstatus_i   (csr_mstatus_i),
        .mepc_wen_o      (mepc_wen_o),
        .mepc_wdata_o    (mepc_wdata_o),
        .mcause_wen_o    (mcause_wen_o),
        .mcause_wdata_o  (mcause_wdata_o),
        .mstatus_wen_o   (mstatus_wen_o),
        .mstatus_wdata_o (mstatus_wdata_o),
        .trap_valid_o    (trap_valid_o),
        .trap_addr_o     (trap_addr_o),
        .irq_ack_o       (irq_ack_o),
        .hold_o          (hold_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] info, input logic [11:0] pend,
                                 input logic [11:0] en, input logic gie,
                                 input logic jmp, input logic [63:0] jpc, input logic [63:0] pc);
        expt_info_i     = info;
        irq_pend_i      = pend;
        irq_en_i        = en;
        global_int_en_i = gie;
        jump_i          = jmp;
        jump_pc_i       = jpc;
        pc_i            = pc;
        #2;
    endtask

    task automatic clearStimulus;
        applyStimulus(4'b0000, 12'h000, 12'h000, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_hold"},  {63'b0, hold_o}, 64'h0);
        checkOutput({tag, "_wen"},   {61'b0, mepc_wen_o, mcause_wen_o, mstatus_wen_o}, 64'h0);
        checkOutput({tag, "_valid"}, {63'b0, trap_valid_o}, 64'h0);
    endtask

    initial begin
        logic [63:0] vec_exp;
        rst = 1'b1;
        csr_mtvec_i   = 64'h8000_1000;
        csr_mepc_i    = 64'h0;
        csr_mstatus_i = 64'h8;
        clearStimulus();
        tick(); tick();
        checkQuiet("rst");
        checkOutput("rst_mstatus_wd", mstatus_wdata_o, 64'h0);
        checkOutput("rst_addr", trap_addr_o, 64'h0);
        checkOutput("rst_mepc_wd", mepc_wdata_o, 64'h0);
        rst = 1'b0;
        tick();

        // ecall
        applyStimulus(4'b0100, 12'h000, 12'h000, 1'b0, 1'b0, 64'h0, 64'h8000_0010);
        checkOutput("ecall_T_hold", {63'b0, hold_o}, 64'h1);
        checkOutput("ecall_T_wen", {63'b0, mepc_wen_o}, 64'h0);
        tick(); clearStimulus();
        checkOutput("ecall_T1_wen", {61'b0, mepc_wen_o, mcause_wen_o, mstatus_wen_o}, 64'h7);
        checkOutput("ecall_mepc", mepc_wdata_o, 64'h8000_0010);
        checkOutput("ecall_mcause", mcause_wdata_o, 64'd11);
        checkOutput("ecall_mstatus", mstatus_wdata_o, 64'h1880);
        checkOutput("ecall_ack", {52'b0, irq_ack_o}, 64'h0);
        checkOutput("ecall_T1_hold", {63'b0, hold_o}, 64'h1);
        checkOutput("ecall_T1_valid", {63'b0, trap_valid_o}, 64'h0);
        tick();
        checkOutput("ecall_T2_valid", {63'b0, trap_valid_o}, 64'h1);
        checkOutput("ecall_T2_addr", trap_addr_o, 64'h8000_1000);
        checkOutput("ecall_T2_hold", {63'b0, hold_o}, 64'h1);
        checkOutput("ecall_T2_wen", {61'b0, mepc_wen_o, mcause_wen_o, mstatus_wen_o}, 64'h0);
        tick();
        checkQuiet("ecall_T3");
        checkOutput("ecall_addr_hold", trap_addr_o, 64'h8000_1000);
        checkOutput("ecall_mstatus_hold", mstatus_wdata_o, 64'h1880);

        // interrupt: highest of 3/7/11 wins, jump target saved
        applyStimulus(4'b0000, 12'h888, 12'hFFF, 1'b1, 1'b1, 64'h8000_0200, 64'h8000_0300);
        checkOutput("irq_T_hold", {63'b0, hold_o}, 64'h1);
        tick(); clearStimulus();
        checkOutput("irq_mcause", mcause_wdata_o, 64'h8000_0000_0000_000B);
        checkOutput("irq_mepc", mepc_wdata_o, 64'h8000_0200);
        checkOutput("irq_ack", {52'b0, irq_ack_o}, 64'h800);
        checkOutput("irq_mstatus", mstatus_wdata_o, 64'h1880);
        tick();
        checkOutput("irq_ack_after", {52'b0, irq_ack_o}, 64'h0);
        checkOutput("irq_addr", trap_addr_o, 64'h8000_1000);
        tick();

        // ecall beats a qualified interrupt
        applyStimulus(4'b0100, 12'h080, 12'hFFF, 1'b1, 1'b0, 64'h0, 64'h8000_0040);
        tick(); clearStimulus();
        checkOutput("prio_mcause", mcause_wdata_o, 64'd11);
        checkOutput("prio_ack", {52'b0, irq_ack_o}, 64'h0);
        checkOutput("prio_mepc", mepc_wdata_o, 64'h8000_0040);
        tick(); tick();

        // illegal beats ecall and ebreak
        applyStimulus(4'b1110, 12'h000, 12'h000, 1'b0, 1'b0, 64'h0, 64'h8000_0050);
        tick(); clearStimulus();
        checkOutput("ill_mcause", mcause_wdata_o, 64'd2);
        tick(); tick();

        // masked interrupts are ignored
        applyStimulus(4'b0000, 12'h080, 12'hFFF, 1'b0, 1'b0, 64'h0, 64'h8000_0060);
        checkQuiet("gie0_T");
        tick();
        checkQuiet("gie0_T1");
        applyStimulus(4'b0000, 12'h080, 12'hF7F, 1'b1, 1'b0, 64'h0, 64'h8000_0060);
        checkQuiet("en0_T");
        tick();
        checkQuiet("en0_T1");
        clearStimulus();

        // mret
        csr_mstatus_i = 64'h1880;
        csr_mepc_i    = 64'h8000_0014;
        applyStimulus(4'b0001, 12'h000, 12'h000, 1'b0, 1'b0, 64'h0, 64'h8000_0070);
        checkOutput("mret_T_hold", {63'b0, hold_o}, 64'h1);
        tick(); clearStimulus();
        checkOutput("mret_wen", {61'b0, mepc_wen_o, mcause_wen_o, mstatus_wen_o}, 64'h1);
        checkOutput("mret_mstatus", mstatus_wdata_o, 64'h1888);
        checkOutput("mret_valid", {63'b0, trap_valid_o}, 64'h1);
        checkOutput("mret_addr", trap_addr_o, 64'h8000_0014);
        tick();
        checkQuiet("mret_T2");

        // vectored mtvec: interrupt offset only when the feature is built in
        csr_mtvec_i   = 64'h8000_1001;
        csr_mstatus_i = 64'h8;
`ifdef TRAP_VECTORED_EN
        vec_exp = 64'h8000_101C;
`else
        vec_exp = 64'h8000_1000;
`endif
        applyStimulus(4'b0000, 12'h080, 12'hFFF, 1'b1, 1'b0, 64'h0, 64'h8000_0080);
        tick(); clearStimulus();
        checkOutput("vec_mcause", mcause_wdata_o, 64'h8000_0000_0000_0007);
        tick();
        checkOutput("vec_irq_addr", trap_addr_o, vec_exp);
        tick();
        applyStimulus(4'b0010, 12'h000, 12'h000, 1'b0, 1'b0, 64'h0, 64'h8000_0090);
        tick(); clearStimulus();
        checkOutput("vec_exc_mcause", mcause_wdata_o, 64'd3);
        tick();
        checkOutput("vec_exc_addr", trap_addr_o, 64'h8000_1000);
        tick();

        // reset in the middle of a trap
        csr_mtvec_i = 64'h8000_1000;
        applyStimulus(4'b0100, 12'h000, 12'h000, 1'b0, 1'b0, 64'h0, 64'h8000_00A0);
        tick(); clearStimulus();
        checkOutput("rstmid_in_trap", {63'b0, mepc_wen_o}, 64'h1);
        rst = 1'b1;
        tick();
        checkQuiet("rstmid_1");
        checkOutput("rstmid_mepc_wd", mepc_wdata_o, 64'h0);
        checkOutput("rstmid_mcause_wd", mcause_wdata_o, 64'h0);
        checkOutput("rstmid_addr", trap_addr_o, 64'h0);
        tick();
        rst = 1'b0;
        tick();
        checkQuiet("rstmid_post1");
        tick();
        checkQuiet("rstmid_post2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
